// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end with a credit-limited request
// stream, an in-order response queue and redirect flushing.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward a response
// straight to the dequeue port when the queue is empty.
module fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            im_req,
  output logic [XLEN-1:0] im_addr,
  input  logic            im_gnt,
  input  logic            im_rvalid,
  input  logic [31:0]     im_rdata,
  output logic            deq_valid,
  input  logic            deq_ready,
  output logic [XLEN-1:0] deq_pc,
  output logic [31:0]     deq_instr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [XLEN-1:0]  fetch_pc_reg, fetch_pc_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] outstanding_reg, outstanding_next;
  logic [CNT_W-1:0] drop_reg, drop_next;
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [PTR_W-1:0] pcq_wr_reg, pcq_wr_next;
  logic [PTR_W-1:0] pcq_rd_reg, pcq_rd_next;

  // Entry storage and the PC FIFO recording addresses of granted requests.
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pcq_mem   [DEPTH];

  logic            credit_ok;
  logic            grant;
  logic            rsp_drop;
  logic            rsp_live;
  logic [XLEN-1:0] rsp_pc;
  logic            queue_valid;
  logic            push;
  logic            q_pop;

  // Queue entries plus in-flight requests must fit in DEPTH slots.
  assign credit_ok = ({1'b0, count_reg} + {1'b0, outstanding_reg}) < DEPTH_C;
  assign im_req    = !rst && !redirect_valid && credit_ok;
  assign im_addr   = fetch_pc_reg;
  assign grant     = im_req && im_gnt;

  // A response is stale while drops are pending or when it races a redirect.
  assign rsp_drop    = im_rvalid && ((drop_reg != '0) || redirect_valid);
  assign rsp_live    = im_rvalid && (drop_reg == '0) && !redirect_valid;
  assign rsp_pc      = pcq_mem[pcq_rd_reg];
  assign queue_valid = (count_reg != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp;
  // Empty queue: a live response is presented on the dequeue port directly.
  assign byp       = !rst && rsp_live && !queue_valid;
  assign deq_valid = (!rst && queue_valid) || byp;
  assign deq_pc    = queue_valid ? pc_mem[head_reg] : rsp_pc;
  assign deq_instr = queue_valid ? instr_mem[head_reg] : im_rdata;
  assign q_pop     = !rst && queue_valid && deq_ready;
  // A bypassed response consumed in the same cycle is never stored.
  assign push      = rsp_live && !(byp && deq_ready);
`else
  assign deq_valid = !rst && queue_valid;
  assign deq_pc    = pc_mem[head_reg];
  assign deq_instr = instr_mem[head_reg];
  assign q_pop     = deq_valid && deq_ready;
  assign push      = rsp_live;
`endif

  // Next-state computation for PC, counters and pointers.
  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    count_next       = count_reg;
    outstanding_next = outstanding_reg + CNT_W'(grant) - CNT_W'(im_rvalid);
    drop_next        = drop_reg;
    head_next        = head_reg;
    tail_next        = tail_reg;
    pcq_wr_next      = pcq_wr_reg + PTR_W'(grant);
    pcq_rd_next      = pcq_rd_reg + PTR_W'(im_rvalid);

    if (redirect_valid) begin
      // Every request still in flight after this edge belongs to the old path.
      fetch_pc_next = redirect_pc & ~XLEN'(3);
      drop_next     = outstanding_next;
      count_next    = '0;
      head_next     = tail_reg;
    end else begin
      if (grant) begin
        fetch_pc_next = fetch_pc_reg + XLEN'(4);
      end
      if (rsp_drop) begin
        drop_next = drop_reg - CNT_W'(1);
      end
      count_next = count_reg + CNT_W'(push) - CNT_W'(q_pop);
      head_next  = head_reg + PTR_W'(q_pop);
      tail_next  = tail_reg + PTR_W'(push);
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      count_reg       <= '0;
      outstanding_reg <= '0;
      drop_reg        <= '0;
      head_reg        <= '0;
      tail_reg        <= '0;
      pcq_wr_reg      <= '0;
      pcq_rd_reg      <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      head_reg        <= head_next;
      tail_reg        <= tail_next;
      pcq_wr_reg      <= pcq_wr_next;
      pcq_rd_reg      <= pcq_rd_next;
    end
  end

  // Storage writes: entries on push, request PCs on grant; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_reg]    <= rsp_pc;
      instr_mem[tail_reg] <= im_rdata;
    end
    if (grant) begin
      pcq_mem[pcq_wr_reg] <= fetch_pc_reg;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a simple in-order
// memory responder driven from the stimulus sequence.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_pc;
  logic [31:0] deq_instr;

  int tests = 0;
  int failures = 0;
  int ngrant = 0;
  bit auto_rsp = 1'b1;
  logic [31:0] pend[$];

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .im_req(im_req),
    .im_addr(im_addr),
    .im_gnt(im_gnt),
    .im_rvalid(im_rvalid),
    .im_rdata(im_rdata),
    .deq_valid(deq_valid),
    .deq_ready(deq_ready),
    .deq_pc(deq_pc),
    .deq_instr(deq_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] dfun(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: record the grant, then let the responder present the next reply.
  task automatic tick();
    logic        g;
    logic [31:0] a;
    #1;
    g = im_req && im_gnt && !rst;
    a = im_addr;
    @(posedge clk);
    if (g) begin
      pend.push_back(a);
      ngrant++;
    end
    #1;
    if (rst) begin
      pend.delete();
      im_rvalid = 1'b0;
      im_rdata  = '0;
    end else if (auto_rsp && pend.size() > 0) begin
      im_rvalid = 1'b1;
      im_rdata  = dfun(pend.pop_front());
    end else begin
      im_rvalid = 1'b0;
      im_rdata  = '0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pend.delete();
    im_rvalid = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] tmp;
    bit found;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    im_gnt = 1'b1;
    im_rvalid = 1'b0;
    im_rdata = '0;
    deq_ready = 1'b1;

    // Reset state and first cycle after release
    @(negedge clk);
    #1;
    check("rst_im_req", im_req, 0);
    check("rst_deq_valid", deq_valid, 0);
    check("rst_im_addr", im_addr, 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_im_req", im_req, 1);
    check("post_rst_im_addr", im_addr, 32'h0);

    // Streaming with 1-cycle latency and deq_ready=1
    tick();
    check("stream_c1_valid", deq_valid, (LAT == 1) ? 1 : 0);
    for (int k = 2; k <= 7; k++) begin
      tick();
      check("stream_valid", deq_valid, 1);
      check("stream_pc", deq_pc, 32'(4 * (k - LAT)));
      check("stream_instr", deq_instr, dfun(32'(4 * (k - LAT))));
    end

    // Mid-operation reset is immediate
    rst = 1'b1;
    #1;
    check("midrst_im_req", im_req, 0);
    check("midrst_deq_valid", deq_valid, 0);
    tick();
    rst = 1'b0;
    pend.delete();
    im_rvalid = 1'b0;

    // Credit limit with deq_ready=0: four grants, then stall
    deq_ready = 1'b0;
    ngrant = 0;
    for (int i = 0; i < 5; i++) tick();
    check("full_im_req", im_req, 0);
    check("full_ngrant", ngrant, 4);
    check("full_deq_valid", deq_valid, 1);
    check("full_deq_pc", deq_pc, 32'h0);
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    check("pop1_deq_pc", deq_pc, 32'h4);
    check("pop1_im_req", im_req, 1);
    check("pop1_im_addr", im_addr, 32'h10);
    for (int i = 0; i < 3; i++) tick();
    check("refill_ngrant", ngrant, 5);
    check("refill_im_req", im_req, 0);

    // Redirect with three requests outstanding
    auto_rsp = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    im_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    check("redir3_im_req", im_req, 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("redir3_im_addr", im_addr, 32'h100);
    check("redir3_im_req_after", im_req, 1);
    im_gnt = 1'b1;
    auto_rsp = 1'b1;
    deq_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (deq_valid) found = 1'b1;
    end
    check("redir3_found", found, 1);
    check("redir3_first_pc", deq_pc, 32'h100);
    check("redir3_first_instr", deq_instr, dfun(32'h100));
    tick();
    check("redir3_second_pc", deq_pc, 32'h104);
    tick();
    check("redir3_third_pc", deq_pc, 32'h108);

    // Redirect coinciding with a response and an offered grant
    tick();
    tick();
    check("race_rvalid_present", im_rvalid, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    check("race_im_req", im_req, 0);
    tick();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (deq_valid) found = 1'b1;
      else tick();
    end
    check("race_found", found, 1);
    check("race_first_pc", deq_pc, 32'h200);

    // Fetch PC wraps at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("wrap_im_req", im_req, 1);
    check("wrap_addr_top", im_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr_zero", im_addr, 32'h0);

    // Response into an empty queue: same-cycle with bypass, one cycle later without
    auto_rsp = 1'b0;
    deq_ready = 1'b0;
    do_reset();
    tick();
    im_gnt = 1'b0;
    tmp = pend.pop_front();
    check("empty_pend_addr", tmp, 32'h0);
    im_rvalid = 1'b1;
    im_rdata = 32'h0000_0013;
    #1;
    check("empty_same_cycle_valid", deq_valid, (LAT == 1) ? 1 : 0);
`ifdef FETCH_QUEUE_BYPASS_EN
    check("empty_same_cycle_instr", deq_instr, 32'h13);
`endif
    tick();
    check("empty_next_valid", deq_valid, 1);
    check("empty_next_instr", deq_instr, 32'h13);
    check("empty_next_pc", deq_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
